// File: rtl/photon_gate_counter_pkg.sv
// Shared types and constants for the gated photon-rate counter.
package photon_gate_counter_pkg;

   localparam int         DIGITS_DEFAULT = 8;
   localparam logic [3:0] BCD_NINE       = 4'd9;

   typedef enum logic {ST_IDLE, ST_GATE} gate_state_e;
   typedef enum logic {ST_ARMED, ST_HOLD} hold_state_e;

endpackage

// File: rtl/photon_gate_counter_zbcd_digit.sv
// One packed-BCD digit of the accumulator ripple chain (purely combinational).
module zbcd_digit
   import photon_gate_counter_pkg::*;
(
   input  logic       inc_in,
   input  logic [3:0] value,
   output logic [3:0] value_next,
   output logic       carry_out,
   output logic       is_nine
);

   always_comb begin
      is_nine    = (value == BCD_NINE);
      carry_out  = inc_in & is_nine;
      value_next = value;
      if (inc_in) begin
         value_next = is_nine ? 4'd0 : value + 4'd1;
      end
   end

endmodule

// File: rtl/photon_gate_counter.sv
// Gated photon-rate counter: synchronised edge detect, dead-time holdoff,
// saturating BCD accumulation over back-to-back fixed windows.
module photon_gate_counter
   import photon_gate_counter_pkg::*;
#(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int DEAD_CYCLES = 5,
   parameter int DIGITS      = DIGITS_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                clear,
   input  logic                pulse_in,
   output logic [4*DIGITS-1:0] count_bcd,
   output logic                overflow,
   output logic                valid,
   output logic                gate_active,
   output logic                dead_active
);

   localparam int GW = $clog2(GATE_CYCLES);
   localparam int HW = $clog2(DEAD_CYCLES + 2);
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [GW-1:0] GATE_ONE  = GW'(1);
   localparam logic [HW-1:0] DEAD_LOAD = HW'(DEAD_CYCLES);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

   logic [1:0]          sync_q, sync_d;
   logic                prev_q, prev_d;
   hold_state_e         hold_state_q, hold_state_d;
   logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
   gate_state_e         gate_state_q, gate_state_d;
   logic [GW-1:0]       gate_cnt_q, gate_cnt_d;
   logic [4*DIGITS-1:0] acc_q, acc_d;
   logic                ovf_acc_q, ovf_acc_d;
   logic [4*DIGITS-1:0] count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                valid_q, valid_d;

   logic                edge_det;
   logic                accept;
   logic                inc;
   logic                acc_sat;
   logic [4*DIGITS-1:0] acc_ripple;
   logic [4*DIGITS-1:0] acc_step;
   logic                ovf_step;
   logic [DIGITS:0]     carry;
   logic [DIGITS-1:0]   nine;

   // Input path and holdoff; the holdoff ignores window boundaries.
   always_comb begin
      sync_d       = {sync_q[0], pulse_in};
      prev_d       = sync_q[1];
      edge_det     = sync_q[1] & ~prev_q;
      accept       = 1'b0;
      hold_state_d = hold_state_q;
      hold_cnt_d   = hold_cnt_q;
      case (hold_state_q)
         ST_ARMED: begin
            if (edge_det) begin
               accept = 1'b1;
               if (DEAD_CYCLES != 0) begin
                  hold_state_d = ST_HOLD;
                  hold_cnt_d   = DEAD_LOAD;
               end
            end
         end
         ST_HOLD: begin
            hold_cnt_d = hold_cnt_q - HOLD_ONE;
            if (hold_cnt_q == HOLD_ONE) begin
               hold_state_d = ST_ARMED;
            end
         end
         default: hold_state_d = ST_ARMED;
      endcase
      if (clear) begin
         hold_state_d = ST_ARMED;
         hold_cnt_d   = '0;
      end
   end

   assign inc      = accept & (gate_state_q == ST_GATE);
   assign carry[0] = inc;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      zbcd_digit u_digit (
         .inc_in     (carry[g]),
         .value      (acc_q[4*g +: 4]),
         .value_next (acc_ripple[4*g +: 4]),
         .carry_out  (carry[g+1]),
         .is_nine    (nine[g])
      );
   end

   // Top carry only fires with every digit at 9; the value then holds.
   assign acc_sat  = carry[DIGITS] & (&nine);
   assign acc_step = acc_sat ? acc_q : acc_ripple;
   assign ovf_step = ovf_acc_q | acc_sat;

   always_comb begin
      gate_state_d = gate_state_q;
      gate_cnt_d   = gate_cnt_q;
      acc_d        = acc_q;
      ovf_acc_d    = ovf_acc_q;
      count_d      = count_q;
      overflow_d   = overflow_q;
      valid_d      = 1'b0;
      case (gate_state_q)
         ST_IDLE: begin
            gate_cnt_d = '0;
            acc_d      = '0;
            ovf_acc_d  = 1'b0;
            if (en) begin
               gate_state_d = ST_GATE;
            end
         end
         ST_GATE: begin
            if (!en) begin
               gate_state_d = ST_IDLE;
               gate_cnt_d   = '0;
               acc_d        = '0;
               ovf_acc_d    = 1'b0;
            end else if (gate_cnt_q == GATE_LAST) begin
               count_d    = acc_step;
               overflow_d = ovf_step;
               valid_d    = 1'b1;
               gate_cnt_d = '0;
               acc_d      = '0;
               ovf_acc_d  = 1'b0;
            end else begin
               gate_cnt_d = gate_cnt_q + GATE_ONE;
               acc_d      = acc_step;
               ovf_acc_d  = ovf_step;
            end
         end
         default: gate_state_d = ST_IDLE;
      endcase
      if (clear) begin
         gate_state_d = ST_IDLE;
         gate_cnt_d   = '0;
         acc_d        = '0;
         ovf_acc_d    = 1'b0;
         count_d      = '0;
         overflow_d   = 1'b0;
         valid_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= '0;
         prev_q       <= 1'b0;
         hold_state_q <= ST_ARMED;
         hold_cnt_q   <= '0;
         gate_state_q <= ST_IDLE;
         gate_cnt_q   <= '0;
         acc_q        <= '0;
         ovf_acc_q    <= 1'b0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         prev_q       <= prev_d;
         hold_state_q <= hold_state_d;
         hold_cnt_q   <= hold_cnt_d;
         gate_state_q <= gate_state_d;
         gate_cnt_q   <= gate_cnt_d;
         acc_q        <= acc_d;
         ovf_acc_q    <= ovf_acc_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         valid_q      <= valid_d;
      end
   end

   assign count_bcd   = count_q;
   assign overflow    = overflow_q;
   assign valid       = valid_q;
   assign gate_active = (gate_state_q == ST_GATE);
   assign dead_active = (hold_state_q == ST_HOLD);

endmodule
